// File: rtl/gpio_pkg.sv
// Shared GPIO definitions: FSM state encodings and counter-width helper.
package gpio_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ON   = 2'd1,
        ST_OFF  = 2'd2
    } gpio_state_t;

    // Bits needed to hold max-1; never returns zero so a 1-cycle timer still has a register.
    function automatic int CNT_W(input int max);
        return (max < 2) ? 1 : $clog2(max);
    endfunction

endpackage

// File: rtl/gpio_hold_timer.sv
// Loadable down-counter that stops at zero; shared by the ON and OFF phases.
module gpio_hold_timer #(
    parameter int W = 8
) (
    input  logic         src_clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] tmr;

    always_ff @(posedge src_clk or negedge rst_n) begin
        if (!rst_n)
            tmr <= '0;
        else if (load)
            tmr <= load_val;
        else if (tmr != '0)
            tmr <= tmr - W'(1);
    end

    assign zero = (tmr == '0);

endmodule

// File: rtl/gpio_pulse_out.sv
// Drives a GPIO pin with min-width pulses, queuing strobes that arrive mid-pulse.
module gpio_pulse_out
    import gpio_pkg::*;
#(
    parameter int ON_CYCLES  = 5_000_000,
    parameter int OFF_CYCLES = 5_000_000,
    parameter int PEND_W     = 4,
    parameter int ACTIVE_LOW = 0
) (
    input  logic              src_clk,
    input  logic              rst_n,
    input  logic              trig,
    output logic              pin_out,
    output logic              busy,
    output logic [PEND_W-1:0] pend_cnt,
    output logic              overflow
);

    localparam int               TMR_W    = CNT_W((ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES);
    localparam logic [TMR_W-1:0] ON_LOAD  = TMR_W'(ON_CYCLES - 1);
    localparam logic [TMR_W-1:0] OFF_LOAD = TMR_W'(OFF_CYCLES - 1);
    localparam logic [PEND_W-1:0] PEND_MAX = '1;
    localparam logic             INACT    = 1'(ACTIVE_LOW);

    gpio_state_t       state, nxt;
    logic              tmr_load, tmr_zero;
    logic [TMR_W-1:0]  tmr_val;
    logic              enq, deq;
    logic [PEND_W-1:0] pend_nxt;
    logic              ovf_nxt;

    gpio_hold_timer #(.W(TMR_W)) u_tmr (
        .src_clk  (src_clk),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .load_val (tmr_val),
        .zero     (tmr_zero)
    );

    // A trig coinciding with OFF end is both queued and dequeued, so it restarts ON without an IDLE gap.
    always_comb begin
        nxt      = state;
        tmr_load = 1'b0;
        tmr_val  = ON_LOAD;
        deq      = 1'b0;
        enq      = trig && (state != ST_IDLE);
        case (state)
            ST_IDLE: begin
                if (trig) begin
                    nxt      = ST_ON;
                    tmr_load = 1'b1;
                end
            end
            ST_ON: begin
                if (tmr_zero) begin
                    nxt      = ST_OFF;
                    tmr_load = 1'b1;
                    tmr_val  = OFF_LOAD;
                end
            end
            ST_OFF: begin
                if (tmr_zero) begin
                    if ((pend_cnt != '0) || trig) begin
                        nxt      = ST_ON;
                        tmr_load = 1'b1;
                        deq      = 1'b1;
                    end else begin
                        nxt = ST_IDLE;
                    end
                end
            end
            default: nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        pend_nxt = pend_cnt;
        ovf_nxt  = 1'b0;
        case ({enq, deq})
            2'b10: begin
                if (pend_cnt == PEND_MAX)
                    ovf_nxt = 1'b1;
                else
                    pend_nxt = pend_cnt + PEND_W'(1);
            end
            2'b01:   pend_nxt = pend_cnt - PEND_W'(1);
            default: pend_nxt = pend_cnt;
        endcase
    end

    always_ff @(posedge src_clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            pend_cnt <= '0;
            overflow <= 1'b0;
            pin_out  <= INACT;
        end else begin
            state    <= nxt;
            pend_cnt <= pend_nxt;
            overflow <= ovf_nxt;
            pin_out  <= (nxt == ST_ON) ? ~INACT : INACT;
        end
    end

    assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_gpio_pulse_out.sv
// Directed bench for gpio_pulse_out with ON=4, OFF=3, PEND_W=2, both pin polarities.
module tb_gpio_pulse_out;

    localparam int ON = 4;
    localparam int OFF = 3;
    localparam int PW = 2;

    logic          src_clk = 1'b0;
    logic          rst_n   = 1'b0;
    logic          trig    = 1'b0;
    logic          pin0, busy0, ovf0, pin1, busy1, ovf1;
    logic [PW-1:0] pend0, pend1;

    int          cyc;
    int          checks;
    int          errors;
    logic [63:0] tm;

    gpio_pulse_out #(.ON_CYCLES(ON), .OFF_CYCLES(OFF), .PEND_W(PW), .ACTIVE_LOW(0)) dut_hi (
        .src_clk (src_clk), .rst_n (rst_n), .trig (trig),
        .pin_out (pin0), .busy (busy0), .pend_cnt (pend0), .overflow (ovf0)
    );

    gpio_pulse_out #(.ON_CYCLES(ON), .OFF_CYCLES(OFF), .PEND_W(PW), .ACTIVE_LOW(1)) dut_lo (
        .src_clk (src_clk), .rst_n (rst_n), .trig (trig),
        .pin_out (pin1), .busy (busy1), .pend_cnt (pend1), .overflow (ovf1)
    );

    always #5 src_clk = ~src_clk;

    // Pulses start at cycle 11 and repeat every ON+OFF=7 cycles up to 'last'.
    function automatic logic pulse_at(input int c, input int last);
        return (c >= 11) && (c <= last) && (((c - 11) % 7) < 4);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cyc=%0d: got %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge src_clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        trig  = 1'b0;
        repeat (2) @(posedge src_clk);
        #1;
        rst_n = 1'b1;
        cyc   = 0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        cyc    = 0;

        // Reset values
        do_reset();
        chk("rst_pin", pin0, 0);
        chk("rst_pin_al", pin1, 1);
        chk("rst_busy", busy0, 0);
        chk("rst_pend", pend0, 0);
        chk("rst_ovf", ovf0, 0);

        // Single trig at cycle 10, both polarities
        tm = '0; tm[10] = 1'b1;
        for (int c = 0; c < 20; c++) begin
            chk("s1_pin", pin0, pulse_at(c, 14));
            chk("s1_pin_al", pin1, !pulse_at(c, 14));
            chk("s1_busy", busy0, (c >= 11) && (c <= 17));
            chk("s1_busy_al", busy1, (c >= 11) && (c <= 17));
            chk("s1_pend", pend0, 0);
            trig = tm[c];
            tick();
        end

        // Three trigs at 10, 12, 13
        do_reset();
        tm = '0; tm[10] = 1'b1; tm[12] = 1'b1; tm[13] = 1'b1;
        for (int c = 0; c < 35; c++) begin
            chk("s2_pin", pin0, pulse_at(c, 31));
            chk("s2_busy", busy0, (c >= 11) && (c <= 31));
            chk("s2_pend", pend0, (c < 13) ? 0 : (c == 13) ? 1 : (c <= 17) ? 2 : (c <= 24) ? 1 : 0);
            chk("s2_ovf", ovf0, 0);
            trig = tm[c];
            tick();
        end

        // trig held 10..14: saturation and overflow
        do_reset();
        tm = '0; for (int i = 10; i <= 14; i++) tm[i] = 1'b1;
        for (int c = 0; c < 42; c++) begin
            chk("s3_pin", pin0, pulse_at(c, 38));
            chk("s3_busy", busy0, (c >= 11) && (c <= 38));
            chk("s3_pend", pend0, (c < 12) ? 0 : (c == 12) ? 1 : (c == 13) ? 2 :
                                  (c <= 17) ? 3 : (c <= 24) ? 2 : (c <= 31) ? 1 : 0);
            chk("s3_ovf", ovf0, c == 15);
            trig = tm[c];
            tick();
        end

        // trig on final OFF cycle with one pending: cancels, no gap
        do_reset();
        tm = '0; tm[10] = 1'b1; tm[12] = 1'b1; tm[17] = 1'b1;
        for (int c = 0; c < 35; c++) begin
            chk("s4_pin", pin0, pulse_at(c, 31));
            chk("s4_busy", busy0, (c >= 11) && (c <= 31));
            chk("s4_pend", pend0, (c < 13) ? 0 : (c <= 24) ? 1 : 0);
            chk("s4_ovf", ovf0, 0);
            trig = tm[c];
            tick();
        end

        // trig on final OFF cycle with nothing pending: straight back to ON
        do_reset();
        tm = '0; tm[10] = 1'b1; tm[17] = 1'b1;
        for (int c = 0; c < 28; c++) begin
            chk("s5_pin", pin0, pulse_at(c, 21));
            chk("s5_busy", busy0, (c >= 11) && (c <= 24));
            chk("s5_pend", pend0, 0);
            chk("s5_ovf", ovf0, 0);
            trig = tm[c];
            tick();
        end

        // Async reset mid-pulse with two pending
        do_reset();
        tm = '0; tm[10] = 1'b1; tm[11] = 1'b1; tm[12] = 1'b1;
        for (int c = 0; c < 13; c++) begin
            chk("s6_pin", pin0, pulse_at(c, 14));
            trig = tm[c];
            tick();
        end
        trig = 1'b0;
        chk("s6_pre_pend", pend0, 2);
        chk("s6_pre_pin", pin0, 1);
        chk("s6_pre_busy", busy0, 1);
        #3;
        rst_n = 1'b0;
        #1;
        chk("s6_async_pin", pin0, 0);
        chk("s6_async_pin_al", pin1, 1);
        chk("s6_async_busy", busy0, 0);
        chk("s6_async_pend", pend0, 0);
        tick();
        tick();
        rst_n = 1'b1;
        for (int c = 0; c < 15; c++) begin
            tick();
            chk("s6_post_pin", pin0, 0);
            chk("s6_post_pin_al", pin1, 1);
            chk("s6_post_busy", busy0, 0);
            chk("s6_post_pend", pend0, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/gpio_pulse_out.md
# gpio_pulse_out

Output-side counterpart of the push-button input path. It accepts single-cycle event strobes from core logic and drives a physical GPIO pin (LED, buzzer, external strobe) with a visible pulse. Each pulse has a guaranteed minimum high time and a minimum low gap. Strobes that arrive while a pulse is in progress are queued in a saturating counter, so every event produces exactly one distinct pulse on the pin. The block sits between core logic and the board pin, in the same clock domain as the input debounce path.

## Interface
- `ON_CYCLES`, default 5_000_000: pin active time per pulse, in `src_clk` cycles; must be ≥1.
- `OFF_CYCLES`, default 5_000_000: minimum inactive gap after each pulse, in cycles; must be ≥1.
- `PEND_W`, default 4: width of the pending-event counter; it saturates at 2^PEND_W−1.
- `ACTIVE_LOW`, default 0: when 1, the pin is inverted so that active means 0.
- `src_clk` in 1: system clock. The block has one clock.
- `rst_n` in 1: reset, asynchronous and active-low.
- `trig` in 1: event strobe, sampled every cycle; a single-cycle pulse is expected.
- `pin_out` out 1: registered drive to the pad.
- `busy` out 1: high whenever the state is not IDLE.
- `pend_cnt` out PEND_W: number of queued events not yet started.
- `overflow` out 1: one-cycle pulse raised when a `trig` is dropped because the queue is saturated.

## Operation
- FSM has three states: IDLE, ON, OFF. A single down-counter `tmr` is shared by ON and OFF.
- IDLE, `trig`=1 → go to ON and load `tmr`=ON_CYCLES−1. `pend_cnt` is unchanged and stays 0.
- ON: `tmr` decrements each cycle. When `tmr`=0, go to OFF and load `tmr`=OFF_CYCLES−1.
- OFF: `tmr` decrements each cycle. When `tmr`=0:
  - if `pend_cnt`>0, decrement `pend_cnt`, go to ON and reload ON_CYCLES−1;
  - otherwise go to IDLE.
- `trig` in ON or OFF increments `pend_cnt`.
  - If `pend_cnt` is already at its maximum, the count is held and `overflow`=1 for that cycle.
- `trig` on the same cycle as the OFF-end dequeue: the increment and decrement cancel, so `pend_cnt` is unchanged. The next ON still starts, and `overflow` is not raised.
- `trig` on the same cycle as the OFF→IDLE transition is counted as pending, so the block goes ON directly instead of to IDLE. Net effect: no event is lost and no extra IDLE cycle is inserted.
- Internal signal `act`=1 only in state ON. `pin_out` = `act` XOR ACTIVE_LOW, registered.
- Reset: state=IDLE, `tmr`=0, `pend_cnt`=0, `busy`=0, `overflow`=0, `pin_out`=ACTIVE_LOW (inactive).
  - Reset applies immediately and asynchronously, including mid-pulse. Queued events are discarded.

## Timing
- Latency: `trig` sampled high at edge k, from IDLE → `pin_out` active from edge k+1.
- The pin stays active for exactly ON_CYCLES cycles, then inactive for exactly OFF_CYCLES cycles.
- Back-to-back queued pulses have a period of exactly ON_CYCLES+OFF_CYCLES. There is no idle cycle between them.
- `busy` rises together with `pin_out`. It falls on the edge where OFF ends with no pending event.
- `pend_cnt` and `overflow` update on the edge after the `trig` is sampled.
- `trig` held high for N cycles counts as N events; no edge detection is applied.
- Counter width is $clog2(max(ON_CYCLES,OFF_CYCLES)). `tmr` never wraps; it is only reloaded.

## Structure
- Shared `gpio_pkg` (alongside the existing config macros) holds:
  - state encodings `ST_IDLE`=2'd0, `ST_ON`=2'd1, `ST_OFF`=2'd2;
  - a `CNT_W(max)` width helper.
- One sub-module, `gpio_hold_timer`: loadable down-counter with a `load` value, `load` strobe and `zero` flag. The FSM and the pending counter stay in the top level.
- Target size is about 150–200 lines of RTL.

## Test plan
All scenarios use ON_CYCLES=4, OFF_CYCLES=3, PEND_W=2.
- Single `trig` at cycle 10 → `pin_out` high on cycles 11–14 and low on 15–17; `busy` falls at 18; `pend_cnt` stays 0.
- Three `trig`s at cycles 10, 12, 13 → three pulses starting at 11, 18, 25; `pend_cnt` goes 1, 2, then 1, then 0; `busy` falls at 32.
- Five `trig`s at cycles 10–14 (held high) → `pend_cnt` saturates at 3; `overflow`=1 for the 5th (cycle 15); four pulses in total.
- `trig` exactly on the final OFF cycle with `pend_cnt`=1 → next ON starts with no gap; `pend_cnt` stays 1; no overflow.
- `rst_n` low at cycle 13 mid-pulse with `pend_cnt`=2 → `pin_out` inactive asynchronously, `pend_cnt`=0, `busy`=0; no pulse after release.
- Repeat scenario 1 with ACTIVE_LOW=1 → `pin_out` idles at 1 and is 0 on cycles 11–14.
